// File: rtl/hf_ssp_pkg.sv
// Shared types and default parameters for the HF-mode SSP transmit path.
package hf_ssp_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  localparam int SSP_DATA_W     = 8;
  localparam int SSP_CLK_HALF   = 4;
  localparam int SSP_FIFO_DEPTH = 4;

endpackage

// File: rtl/hf_ssp_fifo.sv
// Small synchronous FIFO with first-word-fall-through output; extra pointer
// bit separates full from empty.
module hf_ssp_fifo
  import hf_ssp_pkg::*;
#(
  parameter int DATA_W = SSP_DATA_W,
  parameter int DEPTH  = SSP_FIFO_DEPTH
) (
  input  logic              ck_1356meg,
  input  logic              nrst,
  input  logic              push,
  input  logic              pop,
  input  logic              flush,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]       wr_ptr_q, wr_ptr_d;
  logic [AW:0]       rd_ptr_q, rd_ptr_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              do_push;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign dout    = mem_q[rd_ptr_q[AW-1:0]];
  assign do_push = push && !full && !flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_push)         wr_ptr_d = wr_ptr_q + (AW+1)'(1);
      if (pop && !empty)   rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge ck_1356meg or negedge nrst) begin
    if (!nrst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: pointers alone define what is valid.
  always_ff @(posedge ck_1356meg) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/hf_ssp_tx.sv
// SSP serializer: buffers parallel words and shifts them MSB-first to the ARM,
// changing data/frame only on ssp_clk falling edges.
module hf_ssp_tx
  import hf_ssp_pkg::*;
#(
  parameter int DATA_W     = SSP_DATA_W,
  parameter int CLK_HALF   = SSP_CLK_HALF,
  parameter int FIFO_DEPTH = SSP_FIFO_DEPTH
) (
  input  logic              ck_1356meg,
  input  logic              nrst,
  input  logic              en,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_valid,
  output logic              data_ready,
  output logic              ssp_clk,
  output logic              ssp_frame,
  output logic              ssp_din,
  output logic              busy,
  output logic              overflow
);

  localparam int BW = $clog2(DATA_W);
  localparam int DW = (CLK_HALF > 1) ? $clog2(CLK_HALF) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_HALF - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);

  state_e            state_q, state_d;
  logic [DW-1:0]     div_cnt_q, div_cnt_d;
  logic              ssp_clk_q, ssp_clk_d;
  logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] shift_reg_q, shift_reg_d;
  logic              ssp_frame_q, ssp_frame_d;
  logic              ssp_din_q, ssp_din_d;
  logic              overflow_q, overflow_d;

  logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [DATA_W-1:0] fifo_dout;
  logic              wrap, fall, load_word;

  assign data_ready = en && !fifo_full;
  assign fifo_push  = data_valid && data_ready;

  hf_ssp_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .ck_1356meg (ck_1356meg),
    .nrst       (nrst),
    .push       (fifo_push),
    .pop        (fifo_pop),
    .flush      (!en),
    .din        (data_in),
    .dout       (fifo_dout),
    .full       (fifo_full),
    .empty      (fifo_empty)
  );

  assign wrap      = (div_cnt_q == DIV_LAST);
  assign fall      = en && wrap && ssp_clk_q;
  // A new word loads from IDLE or right after the last bit, with no gap bit.
  assign load_word = fall && !fifo_empty && (state_q == IDLE || bit_cnt_q == '0);
  assign fifo_pop  = load_word;

  always_comb begin
    div_cnt_d = div_cnt_q;
    ssp_clk_d = ssp_clk_q;
    if (!en) begin
      div_cnt_d = '0;
      ssp_clk_d = 1'b0;
    end else if (wrap) begin
      div_cnt_d = '0;
      ssp_clk_d = !ssp_clk_q;
    end else begin
      div_cnt_d = div_cnt_q + DW'(1);
    end
  end

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_reg_d = shift_reg_q;
    ssp_frame_d = ssp_frame_q;
    ssp_din_d   = ssp_din_q;
    overflow_d  = overflow_q || (en && data_valid && fifo_full);
    if (!en) begin
      state_d     = IDLE;
      ssp_frame_d = 1'b0;
      ssp_din_d   = 1'b0;
      overflow_d  = 1'b0;
    end else if (load_word) begin
      shift_reg_d = fifo_dout;
      ssp_din_d   = fifo_dout[DATA_W-1];
      ssp_frame_d = 1'b1;
      bit_cnt_d   = BIT_LAST;
      state_d     = SHIFT;
    end else if (fall) begin
      if (state_q == SHIFT && bit_cnt_q != '0) begin
        ssp_frame_d = 1'b0;
        shift_reg_d = {shift_reg_q[DATA_W-2:0], 1'b0};
        ssp_din_d   = shift_reg_q[DATA_W-2];
        bit_cnt_d   = bit_cnt_q - BW'(1);
      end else begin
        ssp_frame_d = 1'b0;
        ssp_din_d   = 1'b0;
        state_d     = IDLE;
      end
    end
  end

  always_ff @(posedge ck_1356meg or negedge nrst) begin
    if (!nrst) begin
      state_q     <= IDLE;
      div_cnt_q   <= '0;
      ssp_clk_q   <= 1'b0;
      bit_cnt_q   <= '0;
      shift_reg_q <= '0;
      ssp_frame_q <= 1'b0;
      ssp_din_q   <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_cnt_q   <= div_cnt_d;
      ssp_clk_q   <= ssp_clk_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_reg_q <= shift_reg_d;
      ssp_frame_q <= ssp_frame_d;
      ssp_din_q   <= ssp_din_d;
      overflow_q  <= overflow_d;
    end
  end

  assign ssp_clk   = ssp_clk_q;
  assign ssp_frame = ssp_frame_q;
  assign ssp_din   = ssp_din_q;
  assign overflow  = overflow_q;
  assign busy      = (state_q == SHIFT) || !fifo_empty;

endmodule

// File: tb/tb_hf_ssp_tx.sv
// Bench for hf_ssp_tx: vector table for idle clocking and first word, then
// scoreboarded sequences for streaming, overflow, abort and async reset.
module tb_hf_ssp_tx;
  import hf_ssp_pkg::*;

  localparam int DW = SSP_DATA_W;
  localparam int CH = SSP_CLK_HALF;
  localparam int FD = SSP_FIFO_DEPTH;

  logic          ck = 1'b0, nrst = 1'b0, en = 1'b0, data_valid = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic          data_ready, ssp_clk, ssp_frame, ssp_din, busy, overflow;

  always #5 ck = ~ck;

  hf_ssp_tx #(.DATA_W(DW), .CLK_HALF(CH), .FIFO_DEPTH(FD)) dut (
    .ck_1356meg (ck),
    .nrst       (nrst),
    .en         (en),
    .data_in    (data_in),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .ssp_clk    (ssp_clk),
    .ssp_frame  (ssp_frame),
    .ssp_din    (ssp_din),
    .busy       (busy),
    .overflow   (overflow)
  );

  int tests = 0, fails = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] rx_q[$];

  // ARM-side receiver model: samples on each ssp_clk rise.
  logic          m_prev = 1'b0;
  int            m_cnt = 0, rises = 0, frames = 0, last_frame_rise = 0;
  int            frame_gap = 0, proto_err = 0, idle_one = 0;
  logic [DW-1:0] m_sh = '0;

  always @(negedge ck) begin
    if (!nrst || !en) begin
      m_prev = 1'b0;
      m_cnt  = 0;
    end else begin
      if (ssp_clk && !m_prev) begin
        rises++;
        if (ssp_frame) begin
          if (m_cnt != 0) proto_err++;
          frames++;
          frame_gap       = rises - last_frame_rise;
          last_frame_rise = rises;
          m_sh  = DW'(ssp_din);
          m_cnt = 1;
        end else if (m_cnt != 0) begin
          m_sh = {m_sh[DW-2:0], ssp_din};
          m_cnt++;
        end else if (ssp_din) begin
          idle_one++;
        end
        if (m_cnt == DW) begin
          rx_q.push_back(m_sh);
          m_cnt = 0;
        end
      end
      m_prev = ssp_clk;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_fall();
    logic last;
    bit   got = 0;
    last = ssp_clk;
    for (int i = 0; i < 4*CH + 4 && !got; i++) begin
      @(negedge ck);
      if (last && !ssp_clk) got = 1;
      last = ssp_clk;
    end
    if (!got) begin
      tests++; fails++;
      $display("FAIL wait_fall: no ssp_clk fall within bound");
    end
  endtask

  task automatic push(input logic [DW-1:0] w, input bit accept);
    data_in    = w;
    data_valid = 1'b1;
    if (accept) exp_q.push_back(w);
    @(posedge ck);
    #1 data_valid = 1'b0;
  endtask

  task automatic check_word(input string name);
    bit got = 0;
    for (int i = 0; i < 2000 && !got; i++) begin
      if (rx_q.size() > 0) got = 1;
      else @(negedge ck);
    end
    if (!got) begin
      tests++; fails++;
      $display("FAIL %s: no word received within bound", name);
    end else if (exp_q.size() == 0) begin
      tests++; fails++;
      $display("FAIL %s: got %0h expected nothing", name, rx_q.pop_front());
    end else begin
      chk(name, 32'(rx_q.pop_front()), 32'(exp_q.pop_front()));
    end
  endtask

  task automatic wait_idle(input string name);
    bit got = 0;
    for (int i = 0; i < 2000 && !got; i++) begin
      @(negedge ck);
      if (!busy) got = 1;
    end
    if (!got) begin
      tests++; fails++;
      $display("FAIL %s: busy stuck high", name);
    end
  endtask

  // {en, data_valid, data_in} -> {ssp_clk, ssp_frame, ssp_din, busy, data_ready, overflow}
  typedef struct {
    logic          en;
    logic          dv;
    logic [DW-1:0] din;
    logic [5:0]    exp;
  } vec_t;
  vec_t tbl[24];

  initial begin
    int f0;
    // Rows run from reset release; row i is sampled after edge i+1. A5 is
    // pushed at edge 17, and the first fall event after that is edge 24.
    for (int i = 0; i < 24; i++) begin
      int n;
      n = i + 1;
      tbl[i].en  = 1'b1;
      tbl[i].dv  = (i == 16);
      tbl[i].din = (i == 16) ? DW'(8'hA5) : '0;
      tbl[i].exp = {((n / CH) % 2) == 1, n == 24, n == 24, n >= 17, 1'b1, 1'b0};
    end

    en = 1'b1;
    repeat (3) @(negedge ck);
    chk("rst_clk",   ssp_clk,    0);
    chk("rst_frame", ssp_frame,  0);
    chk("rst_din",   ssp_din,    0);
    chk("rst_busy",  busy,       0);
    chk("rst_ovf",   overflow,   0);
    chk("rst_ready", data_ready, 1);
    nrst = 1'b1;

    for (int i = 0; i < 24; i++) begin
      en         = tbl[i].en;
      data_valid = tbl[i].dv;
      data_in    = tbl[i].din;
      if (tbl[i].dv) exp_q.push_back(tbl[i].din);
      @(posedge ck);
      #1 data_valid = 1'b0;
      @(negedge ck);
      chk($sformatf("vec%0d", i),
          {26'd0, ssp_clk, ssp_frame, ssp_din, busy, data_ready, overflow}, 32'(tbl[i].exp));
    end
    check_word("word_a5");
    wait_idle("idle_a5");
    chk("a5_din_after",   ssp_din,   0);
    chk("a5_frame_after", ssp_frame, 0);

    // Back-to-back pair
    wait_fall();
    f0 = frames;
    push(8'h3C, 1);
    push(8'hC3, 1);
    check_word("word_3c");
    check_word("word_c3");
    wait_idle("idle_pair");
    chk("pair_frames", frames - f0, 2);
    chk("pair_gap",    frame_gap,   DW);

    // Six pushes into a 4-deep FIFO, aligned just after a fall event
    wait_fall();
    for (int k = 1; k <= 6; k++) begin
      push(DW'(8'h10 + k), k <= FD);
      @(negedge ck);
      chk($sformatf("ovf_ready%0d", k), data_ready, (k < FD) ? 1 : 0);
      chk($sformatf("ovf_flag%0d", k),  overflow,   (k > FD) ? 1 : 0);
    end
    for (int k = 1; k <= FD; k++) check_word($sformatf("ovf_word%0d", k));
    wait_idle("idle_ovf");
    chk("ovf_sticky", overflow, 1);
    en = 1'b0;
    @(posedge ck);
    @(negedge ck);
    chk("ovf_clear",     overflow,   0);
    chk("en_low_ready",  data_ready, 0);
    en = 1'b1;

    // Abort mid-word with two words still queued
    wait_fall();
    push(8'h11, 0);
    push(8'h22, 0);
    push(8'h33, 0);
    wait_fall();
    repeat (3) wait_fall();
    en = 1'b0;
    @(posedge ck);
    @(negedge ck);
    chk("abort_clk",   ssp_clk,   0);
    chk("abort_frame", ssp_frame, 0);
    chk("abort_din",   ssp_din,   0);
    chk("abort_busy",  busy,      0);
    en = 1'b1;
    f0 = frames;
    repeat (200) @(negedge ck);
    chk("abort_frames", frames - f0, 0);
    chk("abort_rx",     rx_q.size(), 0);
    chk("abort_idle",   busy,        0);

    // Asynchronous reset mid-word, then a clean word
    wait_fall();
    push(8'h5A, 0);
    wait_fall();
    repeat (2) wait_fall();
    @(posedge ck);
    #3 nrst = 1'b0;
    #1;
    chk("arst_clk",   ssp_clk,    0);
    chk("arst_frame", ssp_frame,  0);
    chk("arst_din",   ssp_din,    0);
    chk("arst_busy",  busy,       0);
    chk("arst_ovf",   overflow,   0);
    chk("arst_ready", data_ready, 1);
    #9 nrst = 1'b1;
    @(negedge ck);
    push(8'h81, 1);
    check_word("word_81");
    wait_idle("idle_81");

    chk("proto_err",  proto_err,    0);
    chk("idle_ones",  idle_one,     0);
    chk("exp_left",   exp_q.size(), 0);
    chk("rx_left",    rx_q.size(),  0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
